// File: rtl/neuron_pkg.sv
// Shared definitions for the neuron MAC accumulator slice.
//   state_t      : FSM states of the accumulator
//   ctrl_t       : ctrl_data scaling selects (SCALED_* shift the result, RAW_* pass it through)
//   PROD_W       : width of the signed 8x8 input*weight product
//   BIAS_PROD_W  : width of the signed bias*BIAS_SCALE product
//   sat_clamp()  : clamps a 64-bit signed value into a signed range of the given width.
//                  Only used when the design is built with NEURON_ACC_SAT_EN defined.
package neuron_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        BIAS,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        CTRL_SCALED_0 = 2'b00,
        CTRL_SCALED_1 = 2'b01,
        CTRL_RAW_0    = 2'b10,
        CTRL_RAW_1    = 2'b11
    } ctrl_t;

    localparam int unsigned PROD_W      = 16;
    localparam int unsigned BIAS_PROD_W = 15;
    localparam logic signed [7:0] BIAS_SCALE = 8'sd127;

    function automatic logic signed [63:0] sat_clamp(input logic signed [63:0] value,
                                                     input int unsigned width);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (width - 1));
        if (value > hi) begin
            return hi;
        end else if (value < lo) begin
            return lo;
        end
        return value;
    endfunction

endpackage

// File: rtl/neuron_mac_product.sv
// Combinational signed 8x8 multiplier for one (input, weight) pair.
// Ports:
//   in_data     in  8      signed activation input
//   w_data      in  8      signed weight
//   product_ext out WIDTH  16-bit signed product, sign-extended to WIDTH
module neuron_mac_product
    import neuron_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic signed [7:0]       in_data,
    input  logic signed [7:0]       w_data,
    output logic signed [WIDTH-1:0] product_ext
);

    logic signed [PROD_W-1:0] product;

    always_comb begin
        product     = PROD_W'(in_data) * PROD_W'(w_data);
        product_ext = WIDTH'(product);
    end

endmodule

// File: rtl/neuron_mac_accumulator.sv
// Neuron MAC accumulator: streams N_INPUTS signed (input, weight) pairs, accumulates
// their products, adds bias*127, applies the ctrl_data scaling and presents the result
// to the activation stage.
// Build option: define NEURON_ACC_SAT_EN to saturate every accumulate and the bias add
// to the signed WIDTH range; without it the arithmetic wraps modulo 2^WIDTH.
// Ports:
//   clk          in   1      clock, all state on rising edge
//   rst_n        in   1      synchronous active-low reset
//   start        in   1      begin a new evaluation (honoured in IDLE or DONE only)
//   ctrl_data    in   2      scaling select, captured on accepted start
//   bias         in   8      signed bias, captured on accepted start
//   in_valid     in   1      in_data/w_data valid this cycle
//   in_data      in   8      signed activation input
//   w_data       in   8      signed weight
//   in_ready     out  1      a pair is accepted this cycle when in_valid is also high
//   a_input      out  WIDTH  signed result to the activation stage
//   ready_signal out  1      a_input valid; held until next accepted start or reset
module neuron_mac_accumulator
    import neuron_pkg::*;
#(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned N_INPUTS = 62,
    parameter int unsigned SHIFT    = 9
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [1:0]              ctrl_data,
    input  logic signed [7:0]       bias,
    input  logic                    in_valid,
    input  logic signed [7:0]       in_data,
    input  logic signed [7:0]       w_data,
    output logic                    in_ready,
    output logic signed [WIDTH-1:0] a_input,
    output logic                    ready_signal
);

    localparam int unsigned CNT_W = $clog2(N_INPUTS + 1);

    state_t                        state;
    state_t                        state_next;
    logic [CNT_W-1:0]              count;
    logic signed [WIDTH-1:0]       acc;
    logic signed [WIDTH-1:0]       acc_next;
    logic signed [WIDTH-1:0]       prod_ext;
    logic signed [BIAS_PROD_W-1:0] bias_prod;
    logic signed [WIDTH-1:0]       bias_ext;
    logic signed [WIDTH-1:0]       sum_raw;
    logic signed [WIDTH-1:0]       result;
    logic signed [7:0]             bias_q;
    ctrl_t                         ctrl_q;
    logic                          start_ok;
    logic                          xfer;
    logic                          last_xfer;

    neuron_mac_product #(
        .WIDTH(WIDTH)
    ) u_product (
        .in_data    (in_data),
        .w_data     (w_data),
        .product_ext(prod_ext)
    );

    always_comb begin
        start_ok  = start && (state == IDLE || state == DONE);
        in_ready  = (state == ACCUM);
        xfer      = in_valid && in_ready;
        last_xfer = xfer && (count == CNT_W'(N_INPUTS - 1));
        bias_prod = BIAS_PROD_W'(bias_q) * BIAS_PROD_W'(BIAS_SCALE);
        bias_ext  = WIDTH'(bias_prod);
    end

`ifdef NEURON_ACC_SAT_EN
    logic signed [63:0] acc_sat;
    logic signed [63:0] sum_sat;

    // Add in 64 bits so the overflow is visible, then clamp back into WIDTH.
    always_comb begin
        acc_sat  = sat_clamp(64'(acc) + 64'(prod_ext), WIDTH);
        sum_sat  = sat_clamp(64'(acc) + 64'(bias_ext), WIDTH);
        acc_next = acc_sat[WIDTH-1:0];
        sum_raw  = sum_sat[WIDTH-1:0];
    end
`else
    always_comb begin
        acc_next = acc + prod_ext;
        sum_raw  = acc + bias_ext;
    end
`endif

    always_comb begin
        result = sum_raw;
        case (ctrl_q)
            CTRL_SCALED_0, CTRL_SCALED_1: result = sum_raw >>> SHIFT;
            default:                      result = sum_raw;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_ok)  state_next = ACCUM;
            ACCUM:   if (last_xfer) state_next = BIAS;
            BIAS:                   state_next = DONE;
            DONE:    if (start_ok)  state_next = ACCUM;
            default:                state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc          <= '0;
            count        <= '0;
            a_input      <= '0;
            ready_signal <= 1'b0;
            bias_q       <= '0;
            ctrl_q       <= CTRL_SCALED_0;
        end else if (start_ok) begin
            acc          <= '0;
            count        <= '0;
            bias_q       <= bias;
            ctrl_q       <= ctrl_t'(ctrl_data);
            ready_signal <= 1'b0;
        end else begin
            if (xfer) begin
                acc   <= acc_next;
                count <= last_xfer ? '0 : count + CNT_W'(1);
            end
            if (state == BIAS) begin
                a_input <= result;
            end
            // Registered from DONE, so the flag rises one cycle after the result is written.
            if (state == DONE) begin
                ready_signal <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_neuron_mac_accumulator.sv
module tb_neuron_mac_accumulator;

    localparam int unsigned N     = 4;
    localparam int unsigned SHIFT = 9;
`ifdef NEURON_ACC_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [1:0]        ctrl_data = 2'b00;
    logic signed [7:0] bias = '0;
    logic              in_valid = 1'b0;
    logic signed [7:0] in_data = '0;
    logic signed [7:0] w_data = '0;

    logic               in_ready32, in_ready16;
    logic               ready32, ready16;
    logic signed [31:0] a32;
    logic signed [15:0] a16;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        longint v32;
        longint v16;
        int     rise;
    } exp_t;
    exp_t exp_q[$];

    neuron_mac_accumulator #(.WIDTH(32), .N_INPUTS(N), .SHIFT(SHIFT)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .start(start), .ctrl_data(ctrl_data), .bias(bias),
        .in_valid(in_valid), .in_data(in_data), .w_data(w_data),
        .in_ready(in_ready32), .a_input(a32), .ready_signal(ready32)
    );

    neuron_mac_accumulator #(.WIDTH(16), .N_INPUTS(N), .SHIFT(SHIFT)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .start(start), .ctrl_data(ctrl_data), .bias(bias),
        .in_valid(in_valid), .in_data(in_data), .w_data(w_data),
        .in_ready(in_ready16), .a_input(a16), .ready_signal(ready16)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: plain integer arithmetic on the whole evaluation.
    function automatic longint model(input int ins[N], input int ws[N], input int b,
                                     input int c, input int w);
        longint acc, hi, lo, span;
        span = longint'(1) <<< w;
        hi   = (longint'(1) <<< (w - 1)) - 1;
        lo   = -(longint'(1) <<< (w - 1));
        acc  = 0;
        for (int i = 0; i < N; i++) begin
            acc += longint'(ins[i]) * longint'(ws[i]);
            if (SAT) acc = (acc > hi) ? hi : (acc < lo) ? lo : acc;
        end
        acc += longint'(b) * 127;
        if (SAT) begin
            acc = (acc > hi) ? hi : (acc < lo) ? lo : acc;
        end else begin
            acc = acc & (span - 1);
            if (acc > hi) acc -= span;
        end
        if (c < 2) acc = acc >>> SHIFT;
        return acc;
    endfunction

    // Monitor: a rising ready_signal presents one result; while held it must not change.
    bit     prev_ready = 1'b0;
    longint held32, held16;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_ready = 1'b0;
        end else begin
            if (ready32 && !prev_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("a_input_w32", longint'(a32), e.v32);
                    check("a_input_w16", longint'(a16), e.v16);
                    check("ready_latency", cyc, e.rise);
                    check("ready_w16", longint'(ready16), 1);
                    check("in_ready_done", longint'(in_ready32), 0);
                end
                held32 = longint'(a32);
                held16 = longint'(a16);
            end else if (ready32 && prev_ready) begin
                check("a_input_hold_w32", longint'(a32), held32);
                check("a_input_hold_w16", longint'(a16), held16);
            end
            prev_ready = ready32;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_a32"}, longint'(a32), 0);
        check({tag, "_a16"}, longint'(a16), 0);
        check({tag, "_ready"}, longint'(ready32), 0);
        check({tag, "_in_ready"}, longint'(in_ready32), 0);
    endtask

    task automatic run_eval(input int ins[N], input int ws[N], input int b, input int c,
                            input bit gaps, input bit mid_start);
        int   k;
        int   guard;
        bit   take;
        bit   was_done;
        exp_t e;
        was_done  = ready32;
        start     = 1'b1;
        bias      = 8'(b);
        ctrl_data = 2'(c);
        tick();
        start = 1'b0;
        if (was_done) check("ready_fall_on_start", longint'(ready32), 0);
        check("in_ready_accum", longint'(in_ready32), 1);
        k = 0;
        guard = 0;
        while (k < N && guard < 200) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
                w_data   = 8'($urandom);
            end else begin
                in_valid = 1'b1;
                in_data  = 8'(ins[k]);
                w_data   = 8'(ws[k]);
            end
            if (mid_start && k == 1) start = 1'b1;
            take = in_valid && in_ready32;
            tick();
            start = 1'b0;
            if (take) k++;
            guard++;
        end
        in_valid = 1'b0;
        check("transfers_done", k, N);
        check("in_ready_bias", longint'(in_ready32), 0);
        check("in_ready_bias_w16", longint'(in_ready16), 0);
        e.v32  = model(ins, ws, b, c, 32);
        e.v16  = model(ins, ws, b, c, 16);
        e.rise = cyc + 2;
        exp_q.push_back(e);
        for (int i = 0; i < 10 && !ready32; i++) tick();
        check("ready_seen", longint'(ready32), 1);
        repeat (2) tick();
    endtask

    int p_in[N];
    int p_w[N];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        check_reset_outputs("reset");

        // Basic run, then with bias and valid gaps.
        p_in = '{10, -2, 4, 1};
        p_w  = '{3, 5, 4, 1};
        run_eval(p_in, p_w, 0, 2, 1'b0, 1'b0);
        run_eval(p_in, p_w, 1, 2, 1'b1, 1'b0);

        // Scaled extremes.
        p_in = '{127, 127, 127, 127};
        p_w  = '{127, 127, 127, 127};
        run_eval(p_in, p_w, 0, 0, 1'b0, 1'b0);
        p_in = '{-128, -128, -128, -128};
        run_eval(p_in, p_w, 0, 1, 1'b0, 1'b0);

        // Reset mid-accumulation, asserted together with start.
        start = 1'b1; bias = 8'sd5; ctrl_data = 2'b10;
        tick();
        start = 1'b0;
        in_valid = 1'b1; in_data = 8'sd50; w_data = 8'sd60;
        repeat (2) tick();
        in_valid = 1'b0;
        rst_n = 1'b0; start = 1'b1;
        tick();
        check_reset_outputs("mid_reset");
        rst_n = 1'b1; start = 1'b0;
        tick();
        check("idle_in_ready", longint'(in_ready32), 0);
        p_in = '{10, -2, 4, 1};
        p_w  = '{3, 5, 4, 1};
        run_eval(p_in, p_w, 0, 2, 1'b0, 1'b0);

        // Start during ACCUM ignored; start from DONE.
        run_eval(p_in, p_w, -3, 3, 1'b1, 1'b1);

        // Overflow of the 16-bit instance (wrap or saturate by build).
        p_in = '{127, 127, 127, 127};
        p_w  = '{127, 127, 127, 127};
        run_eval(p_in, p_w, 0, 2, 1'b0, 1'b0);

        // Randomised evaluations.
        for (int r = 0; r < 24; r++) begin
            for (int i = 0; i < N; i++) begin
                p_in[i] = $urandom_range(0, 255) - 128;
                p_w[i]  = $urandom_range(0, 255) - 128;
            end
            run_eval(p_in, p_w, int'($urandom_range(0, 255)) - 128,
                     int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0);
        end

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
        check("queue_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
